// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational add/sub datapath between two requesters.
// Result returns SETTLE_CYCLES+1 cycles after grant; requests are level-held and wait while busy.
module alu_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       cin0,
    input  logic       cin1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] res,
    output logic       res_cout,
    output logic       busy,
    output logic [1:0] alu_s,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    input  logic [3:0] alu_d,
    input  logic       alu_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_winner;
    logic       pick1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1 = req1 & (~req0 | ~last_winner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            last_winner <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            busy        <= 1'b0;
            res         <= 4'd0;
            res_cout    <= 1'b0;
            alu_s       <= 2'd0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_cin     <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= CNT_LOAD;
                        if (pick1) begin
                            gnt1        <= 1'b1;
                            last_winner <= 1'b1;
                            alu_s       <= op1;
                            alu_a       <= a1;
                            alu_b       <= b1;
                            alu_cin     <= cin1;
                        end else begin
                            gnt0        <= 1'b1;
                            last_winner <= 1'b0;
                            alu_s       <= op0;
                            alu_a       <= a0;
                            alu_b       <= b0;
                            alu_cin     <= cin0;
                        end
                    end
                end
                BUSY: begin
                    // Datapath inputs stay frozen until the capture edge.
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        res      <= alu_d;
                        res_cout <= alu_cout;
                        done0    <= gnt0;
                        done1    <= gnt1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural model of the shared mux+adder datapath.
module tb_alu_share_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = 2'd0, op1 = 2'd0;
    logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
    logic       cin0 = 1'b0, cin1 = 1'b0;
    logic       gnt0, gnt1, done0, done1, res_cout, busy, alu_cin, alu_cout;
    logic [3:0] res, alu_a, alu_b, alu_d;
    logic [1:0] alu_s;
    logic [3:0] bsel;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    // External datapath: operand-B select then 4-bit add.
    always_comb begin
        case (alu_s)
            2'b00:   bsel = alu_b;
            2'b01:   bsel = ~alu_b;
            2'b10:   bsel = 4'b0000;
            default: bsel = 4'b1111;
        endcase
    end
    assign {alu_cout, alu_d} = {1'b0, alu_a} + {1'b0, bsel} + {4'd0, alu_cin};

    always @(negedge clk) if (gnt0 && gnt1) overlap++;

    alu_share_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .res_cout(res_cout), .busy(busy),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_d(alu_d), .alu_cout(alu_cout)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Requester 0 runs one operation alone; checks grant, result and return to idle.
    task automatic txn0(input string tag, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic cin,
                        input logic [3:0] exp_res, input logic exp_cout);
        op0 = op; a0 = a; b0 = b; cin0 = cin; req0 = 1'b1;
        tick(1);
        check({tag, "_gnt"}, {7'd0, gnt0}, 8'd1);
        tick(S);
        check({tag, "_done"}, {6'd0, done1, done0}, 8'b01);
        check({tag, "_res"}, {3'd0, res_cout, res}, {3'd0, exp_cout, exp_res});
        req0 = 1'b0;
        tick(1);
        check({tag, "_idle"}, {5'd0, busy, gnt0, done0}, 8'd0);
    endtask

    initial begin
        // Reset state
        tick(1);
        check("rst_ctl", {2'd0, gnt0, gnt1, done0, done1, busy, res_cout}, 8'd0);
        check("rst_alu", {alu_s, alu_a, alu_cin, 1'b0}, 8'd0);
        check("rst_res", {alu_b, res}, 8'd0);
        rst_n = 1'b1;

        // Basic add from requester 0
        op0 = 2'b00; a0 = 4'b0101; b0 = 4'b0011; cin0 = 1'b0; req0 = 1'b1;
        tick(1);
        check("t1_gnt", {6'd0, gnt1, gnt0}, 8'b01);
        check("t1_busy", {7'd0, busy}, 8'd1);
        check("t1_ops", {alu_a, alu_b}, 8'h53);
        tick(S - 1);
        check("t1_hold", {alu_a, alu_b}, 8'h53);
        check("t1_nodone", {6'd0, done1, done0}, 8'd0);
        tick(1);
        check("t1_done", {6'd0, done1, done0}, 8'b01);
        check("t1_res", {3'd0, res_cout, res}, 8'h08);
        check("t1_gnt_done", {7'd0, gnt0}, 8'd1);
        req0 = 1'b0;
        tick(1);
        check("t1_idle", {5'd0, busy, gnt0, done0}, 8'd0);

        // Subtract from requester 1, operand changed mid-busy
        op1 = 2'b01; a1 = 4'b0111; b1 = 4'b0010; cin1 = 1'b1; req1 = 1'b1;
        tick(1);
        check("t2_gnt", {6'd0, gnt1, gnt0}, 8'b10);
        tick(1);
        a1 = 4'b1111;
        tick(S - 2);
        check("t2_hold", {4'd0, alu_a}, 8'h07);
        tick(1);
        check("t2_done", {6'd0, done1, done0}, 8'b10);
        check("t2_res", {3'd0, res_cout, res}, 8'h15);
        req1 = 1'b0;
        tick(1);
        check("t2_idle", {6'd0, busy, gnt1}, 8'd0);
        check("t2_res_hold", {3'd0, res_cout, res}, 8'h15);

        // Boundary operations
        txn0("dec_wrap", 2'b11, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b0);
        txn0("inc_wrap", 2'b10, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);

        // Both requesting continuously from reset release
        rst_n = 1'b0;
        op0 = 2'b00; a0 = 4'd1; b0 = 4'd1; cin0 = 1'b0;
        op1 = 2'b00; a1 = 4'd2; b1 = 4'd2; cin1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        tick(1);
        overlap = 0;
        rst_n = 1'b1;
        tick(1);
        check("rr_g0", {6'd0, gnt1, gnt0}, 8'b01);
        tick(S);
        check("rr_d0", {6'd0, done1, done0}, 8'b01);
        check("rr_r0", {4'd0, res}, 8'd2);
        tick(2);
        check("rr_g1", {6'd0, gnt1, gnt0}, 8'b10);
        tick(S);
        check("rr_d1", {6'd0, done1, done0}, 8'b10);
        check("rr_r1", {4'd0, res}, 8'd4);
        tick(2);
        check("rr_g2", {6'd0, gnt1, gnt0}, 8'b01);
        tick(S);
        check("rr_d2", {6'd0, done1, done0}, 8'b01);
        tick(2);
        check("rr_g3", {6'd0, gnt1, gnt0}, 8'b10);
        tick(S);
        check("rr_d3", {6'd0, done1, done0}, 8'b10);
        tick(2);
        check("rr_g4", {6'd0, gnt1, gnt0}, 8'b01);
        check("rr_overlap", 8'(overlap), 8'd0);

        // Reset two cycles into busy
        tick(2);
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {2'd0, gnt0, gnt1, done0, done1, busy, res_cout}, 8'd0);
        check("mid_rst_alu", {alu_s, alu_a, alu_cin, 1'b0}, 8'd0);
        check("mid_rst_res", {alu_b, res}, 8'd0);
        tick(1);
        check("mid_rst_nodone", {6'd0, done1, done0}, 8'd0);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_gnt", {6'd0, gnt1, gnt0}, 8'b10);

        // Requester 1 drops request right after grant
        req1 = 1'b0;
        tick(S);
        check("drop_done", {6'd0, done1, done0}, 8'b10);
        check("drop_res", {3'd0, res_cout, res}, 8'h04);
        tick(1);
        check("drop_idle", {6'd0, busy, gnt1}, 8'd0);
        tick(3);
        check("drop_nogrant", {5'd0, busy, gnt1, gnt0}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing arbiter that shares one gate-level add/sub datapath (4-bit mux-select operand stage feeding a 4-bit ripple adder) between two requesters. It latches the granted requester's operation and operands, holds them stable on the datapath for a programmable number of settle cycles to cover gate propagation delay, then captures the sum and carry and returns them with a one-cycle done pulse. It sits between the requesting units and the shared datapath instance; the datapath itself stays purely combinational.

## Interface
- SETTLE_CYCLES, 8, cycles the datapath inputs are held before capture; legal range 1..255. At a 10 ns clock, 8 covers the ~70 ns mux+adder path.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from requester 0 / 1; level, held until done
- op0 / op1  in  2  operation select: 00 A+B+cin, 01 A+~B+cin, 10 A+0+cin, 11 A+1111+cin
- a0, b0 / a1, b1  in  4 each  operands
- cin0 / cin1  in  1  carry-in
- gnt0 / gnt1  out  1  requester owns the datapath; high from grant through done cycle
- done0 / done1  out  1  one-cycle pulse; res/res_cout valid in that cycle
- res  out  4  captured sum
- res_cout  out  1  captured carry-out
- busy  out  1  high whenever state is not IDLE
- alu_s  out  2  to datapath select
- alu_a, alu_b  out  4 each  to datapath operands
- alu_cin  out  1  to datapath carry-in
- alu_d  in  4  datapath sum
- alu_cout  in  1  datapath carry-out

## Operation
- States: IDLE, BUSY, DONE. Registered outputs only; no combinational path from req* or alu_* to any output.
- IDLE: if any req high at a clock edge, arbitrate, latch op/a/b/cin of the winner into alu_s/alu_a/alu_b/alu_cin, set its gnt, load cnt = SETTLE_CYCLES-1, go BUSY. No request: stay IDLE, alu_* hold last values.
- Arbitration: round-robin on last_winner register. Only one requesting: it wins. Both requesting: the one not equal to last_winner wins. last_winner updates on grant; reset value 1, so requester 0 wins the first tie.
- BUSY: alu_* held constant; requester input changes ignored. cnt != 0: decrement. cnt == 0: capture alu_d -> res and alu_cout -> res_cout, go DONE.
- DONE: done of granted requester high for exactly this cycle; gnt still high; next edge -> IDLE, gnt cleared.
- res/res_cout hold their value until the next capture.
- Requester dropping req during BUSY does not abort; the transaction completes and done still pulses.
- Requester keeping req high after done is a new request, arbitrated in the next IDLE cycle with operands sampled then.
- Arithmetic is 4-bit modulo 16; carry-out in res_cout. Subtraction is op 01 with cin=1; decrement is op 11 with cin=0.
- Reset (any time, including mid-BUSY): state IDLE, cnt 0, last_winner 1. gnt0, gnt1, done0, done1, busy, res, res_cout, alu_s, alu_a, alu_b, alu_cin all 0. An interrupted transaction produces no done. Pending requests are re-arbitrated after release.

## Timing
- Grant edge E0: gnt and alu_* valid after E0; busy high after E0.
- Capture at edge E(SETTLE_CYCLES); done high in the cycle after it.
- Return to IDLE at E(SETTLE_CYCLES+1). Earliest next grant is at E(SETTLE_CYCLES+2).
- Request-to-done latency is SETTLE_CYCLES+1 cycles from the grant edge. Throughput is one operation per SETTLE_CYCLES+2 cycles.
- The datapath sees inputs stable for exactly SETTLE_CYCLES full clock periods before capture.

## Test plan
- SETTLE_CYCLES=4, 10 ns clock. req0, op 00, a=0101, b=0011, cin=0 -> gnt0 after E0; alu_a=0101 and alu_b=0011 unchanged through E4; done0 pulses one cycle after E4 with res=1000, res_cout=0; done1 never asserted.
- req1, op 01, a=0111, b=0010, cin=1 -> res=0101, res_cout=1. Changing a1 to 1111 mid-BUSY leaves alu_a=0111 and the result unchanged.
- Boundary ops: op 11, a=0000, cin=0 -> res=1111, res_cout=0 (decrement wraps). op 10, a=1111, cin=1 -> res=0000, res_cout=1.
- req0 and req1 held high continuously from reset release -> grant order 0,1,0,1. Each done is separated by SETTLE_CYCLES+2 cycles; gnt0 and gnt1 are never high together.
- Pull rst_n low two cycles into BUSY -> all outputs 0 immediately, no done. With req1 only high at release, requester 1 is granted on the first edge.
- req1 dropped after grant -> done1 still pulses with the correct result; controller returns to IDLE and issues no further grant.
